// File: rtl/register_bank_if.sv
// Register bank port bundle: write port, two read ports, sequencer status.
// Latency: none (wires only).
// Backpressure: busy from the bank; writes presented while busy are discarded and flagged by wr_drop.
interface register_bank_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
);
    logic                  reg_write_en;
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] rd_value;
    logic [ADDR_WIDTH-1:0] rs1;
    logic [DATA_WIDTH-1:0] rs1_value;
    logic [ADDR_WIDTH-1:0] rs2;
    logic [DATA_WIDTH-1:0] rs2_value;
    logic                  busy;
    logic                  wr_drop;

    // Pipeline side: decode drives read addresses, writeback drives the write port.
    modport master (
        output reg_write_en, rd, rd_value, rs1, rs2,
        input  rs1_value, rs2_value, busy, wr_drop
    );

    // Bank side.
    modport slave (
        input  reg_write_en, rd, rd_value, rs1, rs2,
        output rs1_value, rs2_value, busy, wr_drop
    );
endinterface

// File: rtl/register_bank.sv
// DEPTH x DATA_WIDTH register bank, 1 write / 2 async read ports, post-reset clear sweep.
// Latency: reads combinational; writes visible next edge (same cycle with REGBANK_BYPASS_EN).
// Backpressure: busy high for DEPTH edges after reset; writes then are dropped and pulse wr_drop.
module register_bank #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int ZERO_REG   = 0
) (
    input  logic                clk,
    input  logic                reset,
    register_bank_if.slave      bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [ADDR_WIDTH-1:0]  clr_ptr;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic                   busy;
    logic                   zero_wr;
    logic                   wr_fire;
    logic                   wr_drop_q;

    // A write aimed at the hard-wired zero entry is silently ignored, never a drop.
    assign zero_wr = (ZERO_REG != 0) && (bus.rd == '0);
    assign wr_fire = bus.reg_write_en && !busy && !zero_wr;

    // State register: reset always restarts the sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave CLEAR on the edge that zeroes the last entry.
    always_comb begin
        state_nxt = state;
        if (state == S_CLEAR && clr_ptr == ADDR_WIDTH'(DEPTH - 1)) begin
            state_nxt = S_READY;
        end
    end

    // Outputs of the FSM: the bank is unusable for the whole sweep.
    always_comb begin
        busy = (state == S_CLEAR);
    end

    // Clear pointer walks the array once per sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_ptr <= '0;
        end else if (busy) begin
            clr_ptr <= clr_ptr + 1'b1;
        end
    end

    // Array update: sweep zeroes one entry per edge, otherwise accepted writes land.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (busy) begin
                mem[clr_ptr] <= '0;
            end else if (wr_fire) begin
                mem[bus.rd] <= bus.rd_value;
            end
        end
    end

    // Drop flag: one-cycle pulse for a write that arrived during the sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_drop_q <= 1'b0;
        end else begin
            wr_drop_q <= bus.reg_write_en && busy;
        end
    end

    // Read port 1: later assignments take priority (busy, then zero entry, then bypass).
    always_comb begin
        bus.rs1_value = mem[bus.rs1];
`ifdef REGBANK_BYPASS_EN
        if (wr_fire && bus.rs1 == bus.rd) begin
            bus.rs1_value = bus.rd_value;
        end
`endif
        if (ZERO_REG != 0 && bus.rs1 == '0) begin
            bus.rs1_value = '0;
        end
        if (busy) begin
            bus.rs1_value = '0;
        end
    end

    // Read port 2: same priority as port 1, compared independently.
    always_comb begin
        bus.rs2_value = mem[bus.rs2];
`ifdef REGBANK_BYPASS_EN
        if (wr_fire && bus.rs2 == bus.rd) begin
            bus.rs2_value = bus.rd_value;
        end
`endif
        if (ZERO_REG != 0 && bus.rs2 == '0) begin
            bus.rs2_value = '0;
        end
        if (busy) begin
            bus.rs2_value = '0;
        end
    end

    assign bus.busy    = busy;
    assign bus.wr_drop = wr_drop_q;

endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank: two instances (ZERO_REG 0 and 1) share one stimulus stream.
// Latency: model updates on each rising edge; outputs sampled on the falling edge or 1ns after input changes.
// Backpressure: busy waits are bounded; an expired bound shows up as a wrong edge count.
module tb_register_bank;
    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          reg_write_en = 1'b0;
    logic [AW-1:0] rd = '0;
    logic [DW-1:0] rd_value = '0;
    logic [AW-1:0] rs1 = '0;
    logic [AW-1:0] rs2 = '0;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: contents per instance, edges completed since reset released, drop flag.
    logic [DW-1:0] mdl [2][DEPTH];
    int            cnt = 0;
    logic          drop = 1'b0;

    register_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
    register_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

    assign bus0.reg_write_en = reg_write_en;
    assign bus0.rd           = rd;
    assign bus0.rd_value     = rd_value;
    assign bus0.rs1          = rs1;
    assign bus0.rs2          = rs2;
    assign bus1.reg_write_en = reg_write_en;
    assign bus1.rd           = rd;
    assign bus1.rd_value     = rd_value;
    assign bus1.rs1          = rs1;
    assign bus1.rs2          = rs2;

    register_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    register_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1)) dut_z (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_busy();
        return cnt < DEPTH;
    endfunction

    function automatic logic [DW-1:0] exp_rd(input int z, input logic [AW-1:0] a);
        if (cnt < DEPTH) return '0;
        if (z == 1 && a == 0) return '0;
`ifdef REGBANK_BYPASS_EN
        if (reg_write_en && !(z == 1 && rd == 0) && a == rd) return rd_value;
`endif
        return mdl[z][a];
    endfunction

    // One rising edge: apply the bank's rules to the inputs presented, then move to the falling edge.
    task automatic tick();
        logic          r, w;
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        r = reset; w = reg_write_en; a = rd; v = rd_value;
        @(posedge clk);
        if (r) begin
            cnt  = 0;
            drop = 1'b0;
        end else if (cnt < DEPTH) begin
            drop = w;
            cnt++;
            if (cnt == DEPTH) begin
                for (int z = 0; z < 2; z++)
                    for (int i = 0; i < DEPTH; i++) mdl[z][i] = '0;
            end
        end else begin
            drop = 1'b0;
            if (w) begin
                mdl[0][a] = v;
                if (a != 0) mdl[1][a] = v;
            end
        end
        @(negedge clk);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".busy0"}, {31'd0, bus0.busy},    {31'd0, exp_busy()});
        check({tag, ".busy1"}, {31'd0, bus1.busy},    {31'd0, exp_busy()});
        check({tag, ".drop0"}, {31'd0, bus0.wr_drop}, {31'd0, drop});
        check({tag, ".drop1"}, {31'd0, bus1.wr_drop}, {31'd0, drop});
        check({tag, ".rs1_0"}, {16'd0, bus0.rs1_value}, {16'd0, exp_rd(0, rs1)});
        check({tag, ".rs2_0"}, {16'd0, bus0.rs2_value}, {16'd0, exp_rd(0, rs2)});
        check({tag, ".rs1_1"}, {16'd0, bus1.rs1_value}, {16'd0, exp_rd(1, rs1)});
        check({tag, ".rs2_1"}, {16'd0, bus1.rs2_value}, {16'd0, exp_rd(1, rs2)});
    endtask

    // Run edges until the DUT leaves the sweep (bounded); optionally present a write to r3 after write_at edges.
    task automatic run_clear(input int write_at, output int edges, output int drops);
        edges = 0;
        drops = 0;
        while (bus0.busy === 1'b1 && edges < 20) begin
            reg_write_en = (edges == write_at);
            rd           = 3'd3;
            rd_value     = 16'hBEEF;
            tick();
            edges++;
            if (bus0.wr_drop === 1'b1) drops++;
            check_all("clr");
        end
        reg_write_en = 1'b0;
    endtask

    task automatic read_all_zero(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            rs1 = AW'(a);
            rs2 = AW'(DEPTH - 1 - a);
            #1;
            check({tag, ".rs1"}, {16'd0, bus0.rs1_value}, 32'd0);
            check({tag, ".rs2"}, {16'd0, bus0.rs2_value}, 32'd0);
            check_all(tag);
        end
    endtask

    initial begin
        int edges;
        int drops;

        for (int z = 0; z < 2; z++)
            for (int i = 0; i < DEPTH; i++) mdl[z][i] = '0;

        // Reset state.
        reset = 1'b1;
        tick();
        tick();
        rs1 = 3'd5; rs2 = 3'd1;
        #1;
        check("rst.busy",  {31'd0, bus0.busy},    32'd1);
        check("rst.drop",  {31'd0, bus0.wr_drop}, 32'd0);
        check("rst.rs1",   {16'd0, bus0.rs1_value}, 32'd0);
        check_all("rst");

        // First sweep, then fill every entry with 0xFFFF so the next sweep has stale data to clear.
        reset = 1'b0;
        run_clear(-1, edges, drops);
        for (int a = 0; a < DEPTH; a++) begin
            reg_write_en = 1'b1; rd = AW'(a); rd_value = 16'hFFFF;
            tick();
        end
        reg_write_en = 1'b0;
        rs1 = 3'd6; rs2 = 3'd6;
        #1;
        check("fill.rs1", {16'd0, bus0.rs1_value}, 32'h0000FFFF);

        // Reset pulse, sweep length, and a write dropped two edges after release.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run_clear(2, edges, drops);
        check("clear_edges", edges, 32'd8);
        check("drop_pulses", drops, 32'd1);
        rs1 = 3'd3;
        #1;
        check("dropped_r3", {16'd0, bus0.rs1_value}, 32'd0);
        read_all_zero("post_clear");

        // Normal writes on consecutive edges.
        reg_write_en = 1'b1; rd = 3'd5; rd_value = 16'h1234;
        tick();
        rd = 3'd2; rd_value = 16'hABCD;
        tick();
        reg_write_en = 1'b0; rs1 = 3'd5; rs2 = 3'd2;
        #1;
        check("r5", {16'd0, bus0.rs1_value}, 32'h00001234);
        check("r2", {16'd0, bus0.rs2_value}, 32'h0000ABCD);
        check_all("wr");

        // Same-cycle write versus read of r4.
        reg_write_en = 1'b1; rd = 3'd4; rd_value = 16'h0001;
        tick();
        rd_value = 16'h0F0F; rs1 = 3'd4; rs2 = 3'd4;
        #1;
`ifdef REGBANK_BYPASS_EN
        check("byp.rs1", {16'd0, bus0.rs1_value}, 32'h00000F0F);
        check("byp.rs2", {16'd0, bus0.rs2_value}, 32'h00000F0F);
`else
        check("byp.rs1", {16'd0, bus0.rs1_value}, 32'h00000001);
        check("byp.rs2", {16'd0, bus0.rs2_value}, 32'h00000001);
`endif
        check_all("byp");
        tick();
        reg_write_en = 1'b0;
        #1;
        check("byp_after", {16'd0, bus0.rs1_value}, 32'h00000F0F);

        // Hard-wired zero entry.
        reg_write_en = 1'b1; rd = 3'd0; rd_value = 16'h5555; rs1 = 3'd0; rs2 = 3'd0;
        #1;
        check("zr.same_cycle", {16'd0, bus1.rs1_value}, 32'd0);
        check_all("zr_w");
        tick();
        reg_write_en = 1'b0;
        #1;
        check("zr.rs1",  {16'd0, bus1.rs1_value}, 32'd0);
        check("zr.drop", {31'd0, bus1.wr_drop},   32'd0);
        check("nz.rs1",  {16'd0, bus0.rs1_value}, 32'h00005555);
        check_all("zr");

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            reset        = ($urandom_range(0, 39) == 0);
            reg_write_en = $urandom_range(0, 1);
            rd           = AW'($urandom_range(0, DEPTH - 1));
            rd_value     = DW'($urandom);
            rs1          = AW'($urandom_range(0, DEPTH - 1));
            rs2          = ($urandom_range(0, 3) == 0) ? rd : AW'($urandom_range(0, DEPTH - 1));
            #1;
            check_all("rnd");
            tick();
        end
        reset = 1'b0;
        reg_write_en = 1'b0;
        run_clear(-1, edges, drops);

        // Populate with non-zero data, then reset part-way through a sweep.
        for (int a = 0; a < DEPTH; a++) begin
            reg_write_en = 1'b1; rd = AW'(a); rd_value = DW'(16'h1000 + a);
            tick();
        end
        reg_write_en = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run_clear(-1, edges, drops);
        check("mid_clear_edges", edges, 32'd8);
        read_all_zero("mid_clear");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
